// File: rtl/ts_ddr_write_arbiter.sv
// Round-robin burst writer sharing one Avalon-MM write port between two TS channels.
// Optional per-channel burst counters when TS_ARB_STATS_EN is defined.
module ts_ddr_write_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 26,
  parameter int LEVEL_WIDTH = 9,
  parameter int BURST_LEN   = 16,
  parameter logic [ADDR_WIDTH-1:0] CH0_BASE     = 26'h0,
  parameter logic [ADDR_WIDTH-1:0] CH1_BASE     = 26'h100000,
  parameter logic [ADDR_WIDTH-1:0] REGION_WORDS = 26'h100000
) (
  input  logic                         CLOCK,
  input  logic                         RESET,
  input  logic                         ENABLE,
  input  logic [LEVEL_WIDTH-1:0]       CH0_LEVEL,
  input  logic [DATA_WIDTH-1:0]        CH0_DATA,
  output logic                         CH0_RD,
  input  logic [LEVEL_WIDTH-1:0]       CH1_LEVEL,
  input  logic [DATA_WIDTH-1:0]        CH1_DATA,
  output logic                         CH1_RD,
  output logic [ADDR_WIDTH-1:0]        AVM_ADDRESS,
  output logic [$clog2(BURST_LEN):0]   AVM_BURSTCOUNT,
  output logic                         AVM_WRITE,
  output logic [DATA_WIDTH-1:0]        AVM_WRITEDATA,
  input  logic                         AVM_WAITREQUEST,
  output logic [1:0]                   GRANT,
`ifdef TS_ARB_STATS_EN
  output logic [31:0]                  CH0_BURSTS,
  output logic [31:0]                  CH1_BURSTS,
`endif
  output logic                         CH0_WRAP,
  output logic                         CH1_WRAP
);

  localparam int BW = $clog2(BURST_LEN) + 1;
  localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BW-1:0]          BL_BC  = BW'(BURST_LEN);
  localparam logic [CW-1:0]          LAST   = CW'(BURST_LEN - 1);
  localparam logic [LEVEL_WIDTH-1:0] BL_LVL = LEVEL_WIDTH'(BURST_LEN);
  localparam logic [ADDR_WIDTH-1:0]  BL_A   = ADDR_WIDTH'(BURST_LEN);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                 state, state_nx;
  logic [1:0]             grant_nx;
  logic [ADDR_WIDTH-1:0]  addr_nx;
  logic [BW-1:0]          bc_nx;
  logic                   write_nx;
  logic [CW-1:0]          cnt, cnt_nx;
  logic [ADDR_WIDTH-1:0]  off0, off0_nx, off1, off1_nx;
  logic                   rr, rr_nx;

  logic req0, req1, pick1, accept, last, hit0, hit1;

  assign req0   = CH0_LEVEL >= BL_LVL;
  assign req1   = CH1_LEVEL >= BL_LVL;
  // rr holds the last served channel; ties go to the other one
  assign pick1  = req1 && (!req0 || !rr);
  assign accept = AVM_WRITE && !AVM_WAITREQUEST;
  assign last   = accept && (cnt == LAST);
  assign hit0   = (off0 + BL_A) == REGION_WORDS;
  assign hit1   = (off1 + BL_A) == REGION_WORDS;

  assign CH0_RD        = accept && GRANT[0];
  assign CH1_RD        = accept && GRANT[1];
  assign AVM_WRITEDATA = GRANT[1] ? CH1_DATA : CH0_DATA;
  assign CH0_WRAP      = last && GRANT[0] && hit0;
  assign CH1_WRAP      = last && GRANT[1] && hit1;

  always_comb begin
    state_nx = state;
    grant_nx = GRANT;
    addr_nx  = AVM_ADDRESS;
    bc_nx    = AVM_BURSTCOUNT;
    write_nx = AVM_WRITE;
    cnt_nx   = cnt;
    off0_nx  = off0;
    off1_nx  = off1;
    rr_nx    = rr;
    unique case (state)
      IDLE: begin
        if (ENABLE && (req0 || req1)) begin
          grant_nx = pick1 ? 2'b10 : 2'b01;
          addr_nx  = pick1 ? (CH1_BASE + off1) : (CH0_BASE + off0);
          bc_nx    = BL_BC;
          write_nx = 1'b1;
          cnt_nx   = '0;
          rr_nx    = pick1;
          state_nx = BURST;
        end
      end
      BURST: begin
        if (last) begin
          write_nx = 1'b0;
          grant_nx = 2'b00;
          bc_nx    = '0;
          state_nx = IDLE;
          if (GRANT[0]) off0_nx = hit0 ? '0 : off0 + BL_A;
          if (GRANT[1]) off1_nx = hit1 ? '0 : off1 + BL_A;
        end else if (accept) begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state          <= IDLE;
      GRANT          <= 2'b00;
      AVM_ADDRESS    <= '0;
      AVM_BURSTCOUNT <= '0;
      AVM_WRITE      <= 1'b0;
      cnt            <= '0;
      off0           <= '0;
      off1           <= '0;
      rr             <= 1'b1;
    end else begin
      state          <= state_nx;
      GRANT          <= grant_nx;
      AVM_ADDRESS    <= addr_nx;
      AVM_BURSTCOUNT <= bc_nx;
      AVM_WRITE      <= write_nx;
      cnt            <= cnt_nx;
      off0           <= off0_nx;
      off1           <= off1_nx;
      rr             <= rr_nx;
    end
  end

`ifdef TS_ARB_STATS_EN
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      CH0_BURSTS <= '0;
      CH1_BURSTS <= '0;
    end else begin
      if (last && GRANT[0]) CH0_BURSTS <= CH0_BURSTS + 32'd1;
      if (last && GRANT[1]) CH1_BURSTS <= CH1_BURSTS + 32'd1;
    end
  end
`endif

endmodule
